joy_split_scan: RTL and testbench
=================================

Name: joy_split_scan

Overview:
- Time-multiplexes the single 6-bit JOYSTICK connector between two players through an external splitter.
- Drives the splitter select line (joy_split_out) and waits a settle time after every select change.
- Samples the synchronised joystick lines and debounces each player's vector.
- Presents stable active-low joystick1/joystick2 vectors to MODULO_PRINCIPAL. Sits in the board top between the JOYSTICK pins and the core, clocked by pclk.

Parameters:
- SETTLE_CYCLES, 8, cycles waited after a select change before sampling; legal range 3..255.
- DEBOUNCE_SCANS, 4, consecutive identical samples required before a player's output updates; legal range 1..15.
- JOY_W, 6, joystick vector width.

Ports:
- pclk  in  1  core pixel clock; all logic is on its rising edge.
- I_RESET  in  1  synchronous, active-high reset.
- enable  in  1  1 = two-player split scanning; 0 = single joystick on port A only.
- joy_in  in  JOY_W  raw active-low joystick pins (asynchronous).
- joy_split_out  out  1  splitter select: 0 = player A, 1 = player B.
- joystick1  out  JOY_W  debounced player A, active-low.
- joystick2  out  JOY_W  debounced player B, active-low.
- scan_tick  out  1  one-cycle pulse when a full scan completes.

Behaviour:
- Input synchroniser:
  - joy_in passes through a 2-flop synchroniser; all samples use its output.
  - The synchroniser flops reset to all ones.
- FSM states: A_SETTLE, A_SAMPLE, B_SETTLE, B_SAMPLE.
- Settle counter (8 bit):
  - Cleared on entry to A_SETTLE or B_SETTLE.
  - Increments each cycle in a settle state.
  - Leaves the settle state when count == SETTLE_CYCLES-1, so each settle state lasts exactly SETTLE_CYCLES cycles.
- Sample states last 1 cycle; the sample is taken in that cycle.
- Transitions:
  - A_SETTLE -> A_SAMPLE.
  - A_SAMPLE -> B_SETTLE if enable=1, else -> A_SETTLE.
  - B_SETTLE -> B_SAMPLE.
  - B_SAMPLE -> A_SETTLE.
- Timing: a full split scan takes 2*(SETTLE_CYCLES+1) cycles (18 at defaults). With enable=0 a scan takes SETTLE_CYCLES+1 cycles.
- joy_split_out is registered: 0 in A states, 1 in B states. It changes in the same cycle the FSM enters B_SETTLE or A_SETTLE.
- Debounce, independent per player, on the whole vector (each player has a candidate register cand and counter cnt, 4 bit):
  - On a sample that differs from cand: cand <= sample, cnt <= 1. If DEBOUNCE_SCANS==1, output <= sample in the same cycle.
  - On a sample equal to cand with cnt < DEBOUNCE_SCANS: cnt <= cnt+1. If cnt+1 == DEBOUNCE_SCANS, output <= cand.
  - On a sample equal to cand with cnt == DEBOUNCE_SCANS: no change (counter saturates).
  - The output register updates at the end of the sample cycle and is visible the next cycle.
- scan_tick:
  - 1 during B_SAMPLE when enable=1.
  - 1 during A_SAMPLE when enable=0.
  - 0 otherwise.
- enable deasserted while in B_SETTLE or B_SAMPLE:
  - Next state is A_SETTLE; no B sample is taken, and scan_tick is not pulsed in that cycle.
  - joy_split_out is 0 from the next cycle.
  - While enable=0: joystick2 is forced to all ones, player B cand is reset to all ones, and player B cnt is set to DEBOUNCE_SCANS.
- enable asserted while in A states: takes effect at A_SAMPLE.
- Reset (synchronous, any state, including mid-scan):
  - State A_SETTLE, counter 0, joy_split_out 0, scan_tick 0.
  - joystick1 and joystick2 all ones; both cand all ones; both cnt = DEBOUNCE_SCANS (released is treated as already stable).
- Simultaneous I_RESET and enable change: reset wins.

Test Plan:
- Reset with defaults, joy_in=6'h3F, enable=1 -> joy_split_out toggles 0/1 every 9 cycles, period 18; scan_tick pulses once per 18 cycles; both outputs remain 6'h3F.
- Player A presses fire (joy_in=6'h1F only while joy_split_out=0) -> joystick1=6'h1F one cycle after the 4th A sample (~3 scans after the first); joystick2 stays 6'h3F.
- Glitch: player B input 6'h3E for only 2 consecutive B samples, then 6'h3F -> joystick2 never leaves 6'h3F.
- Drop enable during B_SETTLE -> joy_split_out 0 the next cycle; joystick2=6'h3F; scan_tick pulses every 9 cycles in A_SAMPLE.
- I_RESET pulsed mid-B_SETTLE with joystick1 previously 6'h1F -> next cycle joy_split_out=0, joystick1=6'h3F; the scan restarts at A_SETTLE.
- SETTLE_CYCLES=3, DEBOUNCE_SCANS=1 -> split period 8 cycles; each output follows its sample one cycle after the sample state.

Source files
------------

// File: rtl/joy_split_scan.sv
// Two-player joystick scanner: alternates the external splitter select, waits for the lines to
// settle, samples the synchronised connector and debounces each player's vector.
module joy_split_scan #(
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned JOY_W          = 6
) (
    input  logic             pclk,
    input  logic             I_RESET,
    input  logic             enable,
    input  logic [JOY_W-1:0] joy_in,
    output logic             joy_split_out,
    output logic [JOY_W-1:0] joystick1,
    output logic [JOY_W-1:0] joystick2,
    output logic             scan_tick
);

    localparam logic [7:0]       SettleLast = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       DebScans   = 4'(DEBOUNCE_SCANS);
    localparam logic [JOY_W-1:0] Released   = '1;

    typedef enum logic [1:0] {
        StASettle,
        StASample,
        StBSettle,
        StBSample
    } state_e;

    state_e           state_q;
    logic [7:0]       settle_cnt_q;
    logic             split_q;
    logic [JOY_W-1:0] joy_meta_q;
    logic [JOY_W-1:0] joy_sync_q;
    logic [JOY_W-1:0] cand_a_q;
    logic [JOY_W-1:0] cand_b_q;
    logic [JOY_W-1:0] out_a_q;
    logic [JOY_W-1:0] out_b_q;
    logic [3:0]       cnt_a_q;
    logic [3:0]       cnt_b_q;
    logic             sample_a;
    logic             sample_b;

    always_ff @(posedge pclk) begin
        if (I_RESET) begin
            joy_meta_q <= Released;
            joy_sync_q <= Released;
        end else begin
            joy_meta_q <= joy_in;
            joy_sync_q <= joy_meta_q;
        end
    end

    // Dropping enable anywhere on the B side aborts straight back to player A.
    always_ff @(posedge pclk) begin
        if (I_RESET) begin
            state_q      <= StASettle;
            settle_cnt_q <= 8'd0;
            split_q      <= 1'b0;
        end else begin
            case (state_q)
                StASettle: begin
                    if (settle_cnt_q == SettleLast) begin
                        state_q <= StASample;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
                StASample: begin
                    settle_cnt_q <= 8'd0;
                    if (enable) begin
                        state_q <= StBSettle;
                        split_q <= 1'b1;
                    end else begin
                        state_q <= StASettle;
                    end
                end
                StBSettle: begin
                    if (!enable) begin
                        state_q      <= StASettle;
                        settle_cnt_q <= 8'd0;
                        split_q      <= 1'b0;
                    end else if (settle_cnt_q == SettleLast) begin
                        state_q <= StBSample;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
                StBSample: begin
                    state_q      <= StASettle;
                    settle_cnt_q <= 8'd0;
                    split_q      <= 1'b0;
                end
                default: begin
                    state_q      <= StASettle;
                    settle_cnt_q <= 8'd0;
                    split_q      <= 1'b0;
                end
            endcase
        end
    end

    assign sample_a  = (state_q == StASample);
    assign sample_b  = (state_q == StBSample) && enable;
    assign scan_tick = enable ? (state_q == StBSample) : (state_q == StASample);

    // Released is treated as already stable, so the counters start saturated.
    always_ff @(posedge pclk) begin
        if (I_RESET) begin
            cand_a_q <= Released;
            cnt_a_q  <= DebScans;
            out_a_q  <= Released;
        end else if (sample_a) begin
            if (joy_sync_q != cand_a_q) begin
                cand_a_q <= joy_sync_q;
                cnt_a_q  <= 4'd1;
                if (DebScans == 4'd1) out_a_q <= joy_sync_q;
            end else if (cnt_a_q < DebScans) begin
                cnt_a_q <= cnt_a_q + 4'd1;
                if (cnt_a_q + 4'd1 == DebScans) out_a_q <= cand_a_q;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (I_RESET || !enable) begin
            cand_b_q <= Released;
            cnt_b_q  <= DebScans;
            out_b_q  <= Released;
        end else if (sample_b) begin
            if (joy_sync_q != cand_b_q) begin
                cand_b_q <= joy_sync_q;
                cnt_b_q  <= 4'd1;
                if (DebScans == 4'd1) out_b_q <= joy_sync_q;
            end else if (cnt_b_q < DebScans) begin
                cnt_b_q <= cnt_b_q + 4'd1;
                if (cnt_b_q + 4'd1 == DebScans) out_b_q <= cand_b_q;
            end
        end
    end

    assign joy_split_out = split_q;
    assign joystick1     = out_a_q;
    assign joystick2     = enable ? out_b_q : Released;

endmodule

// File: tb/tb_joy_split_scan.sv
// Bench for joy_split_scan: directed vector table and hand sequences on the default build, plus
// randomized traffic on default and fast builds checked against a scan-position model.
module tb_joy_split_scan;

    localparam int unsigned W = 6;
    localparam logic [W-1:0] Ones = '1;

    logic         pclk = 1'b0;
    logic         I_RESET;
    logic         enable;
    logic [W-1:0] joy_in;
    logic         split0, tick0, split1, tick1;
    logic [W-1:0] j1_0, j2_0, j1_1, j2_1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    logic [W-1:0] a_val, b_val;

    always #5 pclk = ~pclk;

    joy_split_scan dut (
        .pclk(pclk), .I_RESET(I_RESET), .enable(enable), .joy_in(joy_in),
        .joy_split_out(split0), .joystick1(j1_0), .joystick2(j2_0), .scan_tick(tick0)
    );

    joy_split_scan #(.SETTLE_CYCLES(3), .DEBOUNCE_SCANS(1), .JOY_W(W)) dut_fast (
        .pclk(pclk), .I_RESET(I_RESET), .enable(enable), .joy_in(joy_in),
        .joy_split_out(split1), .joystick1(j1_1), .joystick2(j2_1), .scan_tick(tick1)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: t is the cycle position within the current scan (0 = first A settle
    // cycle); each player keeps a history of samples, output = value once the last D agree.
    int           m_s [2] = '{8, 3};
    int           m_d [2] = '{4, 1};
    int           m_t [2];
    logic [W-1:0] m_meta, m_sync;
    logic [W-1:0] m_out  [2][2];
    logic [W-1:0] m_hist [2][2][16];

    function automatic void push(input int c, input int p, input logic [W-1:0] smp);
        bit stable;
        for (int i = 15; i > 0; i--) m_hist[c][p][i] = m_hist[c][p][i-1];
        m_hist[c][p][0] = smp;
        stable = 1'b1;
        for (int i = 0; i < m_d[c]; i++) if (m_hist[c][p][i] != smp) stable = 1'b0;
        if (stable) m_out[c][p] = smp;
    endfunction

    function automatic void release_player(input int c, input int p);
        for (int i = 0; i < 16; i++) m_hist[c][p][i] = Ones;
        m_out[c][p] = Ones;
    endfunction

    always @(negedge pclk) begin
        for (int c = 0; c < 2; c++) begin
            int s;
            logic exp_tick;
            s = m_s[c];
            exp_tick = (m_t[c] == s && !enable) || (m_t[c] == 2 * s + 1 && enable);
            if (chk_en) begin
                check($sformatf("split[%0d]", c), W'(c == 0 ? split0 : split1),
                      W'(m_t[c] > s));
                check($sformatf("tick[%0d]", c), W'(c == 0 ? tick0 : tick1), W'(exp_tick));
                check($sformatf("joy1[%0d]", c), c == 0 ? j1_0 : j1_1, m_out[c][0]);
                check($sformatf("joy2[%0d]", c), c == 0 ? j2_0 : j2_1,
                      enable ? m_out[c][1] : Ones);
            end
            if (I_RESET) begin
                m_t[c] = 0;
                release_player(c, 0);
                release_player(c, 1);
            end else begin
                if (m_t[c] == s) push(c, 0, m_sync);
                if (m_t[c] == 2 * s + 1 && enable) push(c, 1, m_sync);
                if (!enable) release_player(c, 1);
                if (m_t[c] == s) m_t[c] = enable ? s + 1 : 0;
                else if (m_t[c] == 2 * s + 1 || (m_t[c] > s && !enable)) m_t[c] = 0;
                else m_t[c] = m_t[c] + 1;
            end
        end
        if (I_RESET) begin
            m_meta = Ones;
            m_sync = Ones;
        end else begin
            m_sync = m_meta;
            m_meta = joy_in;
        end
    end

    // Advance one cycle and present the selected player's value to the connector.
    task automatic step();
        @(posedge pclk);
        #1;
        joy_in = split0 ? b_val : a_val;
    endtask

    task automatic wait_split(input logic v);
        int n = 0;
        while (split0 !== v && n < 40) begin
            step();
            n++;
        end
        check("wait_split", W'(split0), W'(v));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0: return 6'h3F;
            1: return 6'h1F;
            2: return 6'h3E;
            default: return W'($urandom);
        endcase
    endfunction

    typedef struct {
        int           ncyc;
        logic         en;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp1;
        logic [W-1:0] exp2;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int ticks;
        vecs[0] = '{17, 1'b1, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
        vecs[1] = '{54, 1'b1, 6'h1F, 6'h3F, 6'h3F, 6'h3F};  // only 3 A samples so far
        vecs[2] = '{18, 1'b1, 6'h1F, 6'h3F, 6'h1F, 6'h3F};  // 4th A sample lands
        vecs[3] = '{36, 1'b1, 6'h1F, 6'h3E, 6'h1F, 6'h3F};  // 2-scan B glitch
        vecs[4] = '{36, 1'b1, 6'h1F, 6'h3F, 6'h1F, 6'h3F};
        vecs[5] = '{72, 1'b1, 6'h1F, 6'h3E, 6'h1F, 6'h3F};  // 4th B sample in last cycle
        vecs[6] = '{1,  1'b1, 6'h1F, 6'h3E, 6'h1F, 6'h3E};

        I_RESET = 1'b1;
        enable  = 1'b1;
        a_val   = Ones;
        b_val   = Ones;
        joy_in  = Ones;
        repeat (3) @(posedge pclk);
        #1;
        I_RESET = 1'b0;
        chk_en  = 1'b1;

        @(negedge pclk);
        check("rst_split", W'(split0), W'(1'b0));
        check("rst_tick", W'(tick0), W'(1'b0));
        check("rst_joy1", j1_0, 6'h3F);
        check("rst_joy2", j2_0, 6'h3F);
        step();

        for (int v = 0; v < 7; v++) begin
            a_val  = vecs[v].a;
            b_val  = vecs[v].b;
            enable = vecs[v].en;
            joy_in = split0 ? b_val : a_val;
            for (int c = 0; c < vecs[v].ncyc; c++) begin
                if (c == vecs[v].ncyc - 1) begin
                    @(negedge pclk);
                    check($sformatf("vec%0d_joy1", v), j1_0, vecs[v].exp1);
                    check($sformatf("vec%0d_joy2", v), j2_0, vecs[v].exp2);
                end
                step();
            end
        end

        // Drop enable part-way through B settle.
        a_val = 6'h1F;
        b_val = 6'h3F;
        wait_split(1'b1);
        step();
        step();
        enable = 1'b0;
        @(negedge pclk);
        check("drop_split_hold", W'(split0), W'(1'b1));
        step();
        @(negedge pclk);
        check("drop_split_low", W'(split0), W'(1'b0));
        check("drop_joy2", j2_0, 6'h3F);
        b_val = 6'h3E;
        ticks = 0;
        repeat (27) begin
            @(negedge pclk);
            if (tick0) ticks++;
            step();
        end
        check("single_tick_count", W'(ticks), W'(3));
        check("single_joy2", j2_0, 6'h3F);

        // Reset in the middle of B settle while player A is held.
        b_val  = 6'h3F;
        enable = 1'b1;
        wait_split(1'b1);
        check("pre_rst_joy1", j1_0, 6'h1F);
        step();
        step();
        I_RESET = 1'b1;
        step();
        I_RESET = 1'b0;
        @(negedge pclk);
        check("midrst_split", W'(split0), W'(1'b0));
        check("midrst_joy1", j1_0, 6'h3F);
        check("midrst_joy2", j2_0, 6'h3F);
        repeat (8) step();
        @(negedge pclk);
        check("restart_split_a", W'(split0), W'(1'b0));
        step();
        @(negedge pclk);
        check("restart_split_b", W'(split0), W'(1'b1));

        repeat (3000) begin
            step();
            if ($urandom_range(0, 39) == 0) a_val = pick();
            if ($urandom_range(0, 39) == 0) b_val = pick();
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            I_RESET = ($urandom_range(0, 299) == 0);
            joy_in  = split0 ? b_val : a_val;
            if ($urandom_range(0, 15) == 0) joy_in = W'($urandom);
        end

        @(negedge pclk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
